// File: rtl/packet_filter_pkg.sv
// Shared types and default sizing for the per-port ingress packet buffer.
package packet_filter_pkg;

  localparam int PKT_BUF_DATA_WIDTH = 16;
  localparam int PKT_BUF_IDX_WIDTH  = 2;
  localparam int PKT_BUF_ADDR_WIDTH = 6;
  localparam int PKT_BUF_DESC_WIDTH = 3;

  typedef struct packed {
    logic                          tlast;
    logic [PKT_BUF_DATA_WIDTH-1:0] tdata;
  } pkt_word_t;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    DROP
  } wr_state_t;

endpackage

// File: rtl/pkt_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module pkt_buffer_ram #(
  parameter int WORD_WIDTH = 17,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ingress_pkt_buffer.sv
// Store-and-forward packet buffer: commits whole packets, drops what does not fit,
// and replays committed packets as contiguous AXIS bursts.
module ingress_pkt_buffer
  import packet_filter_pkg::*;
#(
  parameter int DATA_WIDTH = PKT_BUF_DATA_WIDTH,
  parameter int IDX_WIDTH  = PKT_BUF_IDX_WIDTH,
  parameter int ADDR_WIDTH = PKT_BUF_ADDR_WIDTH,
  parameter int DESC_WIDTH = PKT_BUF_DESC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  input  logic                  in_tlast,
  input  logic [IDX_WIDTH-1:0]  in_tdest,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  output logic [IDX_WIDTH-1:0]  out_tdest,
  input  logic                  out_tready,
  output logic [15:0]           drop_count,
  output logic [DESC_WIDTH:0]   pkt_count
);

  localparam int WORD_WIDTH = DATA_WIDTH + 1;
  localparam int DESC_DEPTH = 2**DESC_WIDTH;

  wr_state_t             state_reg;
  logic [ADDR_WIDTH:0]   wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
  logic [IDX_WIDTH-1:0]  cur_dest_reg;
  logic [15:0]           drop_count_reg;
  logic [IDX_WIDTH-1:0]  desc_mem [DESC_DEPTH];
  logic [DESC_WIDTH:0]   desc_wr_ptr_reg, desc_rd_ptr_reg;

  logic                  ram_full, desc_full, desc_empty;
  logic                  ram_wr_en, commit, drop_start;
  logic [IDX_WIDTH-1:0]  push_dest;

  logic                  rd_issue, rd_inflight_reg, pop, pop_last;
  logic [1:0]            buf_count_reg;
  logic [2:0]            occupancy;
  logic [WORD_WIDTH-1:0] skid0_reg, skid1_reg, ram_rd_data;

  // The upstream filter is never back-pressured; overflow is handled by dropping.
  assign in_tready = !reset;

  assign ram_full   = (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);
  assign desc_full  = (desc_wr_ptr_reg[DESC_WIDTH-1:0] == desc_rd_ptr_reg[DESC_WIDTH-1:0]) &&
                      (desc_wr_ptr_reg[DESC_WIDTH] != desc_rd_ptr_reg[DESC_WIDTH]);
  assign desc_empty = (desc_wr_ptr_reg == desc_rd_ptr_reg);

  always_comb begin
    ram_wr_en  = 1'b0;
    drop_start = 1'b0;
    if (in_tvalid && !reset) begin
      case (state_reg)
        IDLE: begin
          ram_wr_en  = !desc_full && !ram_full;
          drop_start = desc_full || ram_full;
        end
        STORE: begin
          ram_wr_en  = !ram_full;
          drop_start = ram_full;
        end
        default: ;
      endcase
    end
  end

  assign commit    = ram_wr_en && in_tlast;
  assign push_dest = (state_reg == IDLE) ? in_tdest : cur_dest_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      commit_ptr_reg  <= '0;
      cur_dest_reg    <= '0;
      desc_wr_ptr_reg <= '0;
      drop_count_reg  <= '0;
    end else begin
      if (ram_wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (commit) begin
        commit_ptr_reg  <= wr_ptr_reg + 1'b1;
        desc_wr_ptr_reg <= desc_wr_ptr_reg + 1'b1;
      end
      if (drop_start && drop_count_reg != 16'hFFFF)
        drop_count_reg <= drop_count_reg + 16'd1;
      if (in_tvalid) begin
        case (state_reg)
          IDLE: begin
            if (ram_wr_en)
              cur_dest_reg <= in_tdest;
            if (!in_tlast)
              state_reg <= ram_wr_en ? STORE : DROP;
          end
          STORE: begin
            if (ram_full) begin
              // Discard the partial packet by rewinding to the last commit point.
              wr_ptr_reg <= commit_ptr_reg;
              state_reg  <= in_tlast ? IDLE : DROP;
            end else if (in_tlast) begin
              state_reg <= IDLE;
            end
          end
          default: begin
            if (in_tlast)
              state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit)
      desc_mem[desc_wr_ptr_reg[DESC_WIDTH-1:0]] <= push_dest;
  end

  pkt_buffer_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wr_data ({in_tlast, in_tdata}),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  assign out_tvalid = (buf_count_reg != 2'd0);
  assign out_tdata  = skid0_reg[DATA_WIDTH-1:0];
  assign out_tlast  = out_tvalid && skid0_reg[DATA_WIDTH];
  assign out_tdest  = desc_empty ? '0 : desc_mem[desc_rd_ptr_reg[DESC_WIDTH-1:0]];
  assign pop        = out_tvalid && out_tready;
  assign pop_last   = pop && skid0_reg[DATA_WIDTH];

  // Buffered plus in-flight words never exceed the two skid slots.
  assign occupancy  = {1'b0, buf_count_reg} + {2'b00, rd_inflight_reg};
  assign rd_issue   = (rd_ptr_reg != commit_ptr_reg) && (occupancy < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg      <= '0;
      rd_inflight_reg <= 1'b0;
      buf_count_reg   <= '0;
      skid0_reg       <= '0;
      skid1_reg       <= '0;
      desc_rd_ptr_reg <= '0;
    end else begin
      rd_inflight_reg <= rd_issue;
      if (rd_issue)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (pop_last)
        desc_rd_ptr_reg <= desc_rd_ptr_reg + 1'b1;
      case ({pop, rd_inflight_reg})
        2'b11: begin
          if (buf_count_reg == 2'd1) begin
            skid0_reg <= ram_rd_data;
          end else begin
            skid0_reg <= skid1_reg;
            skid1_reg <= ram_rd_data;
          end
        end
        2'b10: begin
          skid0_reg     <= skid1_reg;
          buf_count_reg <= buf_count_reg - 2'd1;
        end
        2'b01: begin
          if (buf_count_reg == 2'd0)
            skid0_reg <= ram_rd_data;
          else
            skid1_reg <= ram_rd_data;
          buf_count_reg <= buf_count_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign drop_count = drop_count_reg;
  assign pkt_count  = desc_wr_ptr_reg - desc_rd_ptr_reg;

endmodule
